// File: rtl/tile_accumulate.sv
// ============================================================================
// tile_accumulate
//
// Streaming reduction stage. Sums every ACC_LEN consecutive signed DATA_W-bit
// input words into one result word, emits one result per group, and after
// NUM_TILES results signals completion through HLS-style ap_* control.
//
// Optional feature macro: TILE_ACCUMULATE_SATURATE_EN
//   defined   : every addition clamps to the signed DATA_W range, and the
//               running sum keeps the clamped value
//   undefined : two's-complement wrap, no clamp logic
//
// Ports
//   ap_clk             in   sole clock, rising edge
//   ap_rst_n           in   synchronous active-low reset
//   ap_start           in   level start, sampled only in IDLE
//   ap_done            out  one-cycle pulse when the run completes
//   ap_idle            out  high while in IDLE
//   ap_ready           out  one-cycle pulse, coincident with ap_done
//   Input_1_V_TDATA    in   signed partial product
//   Input_1_V_TVALID   in   input word valid
//   Input_1_V_TREADY   out  input word accepted
//   Output_1_V_TDATA   out  signed accumulated result
//   Output_1_V_TVALID  out  result valid
//   Output_1_V_TREADY  in   downstream accepts the result
// ============================================================================
module tile_accumulate #(
    parameter int DATA_W    = 32,
    parameter int ACC_LEN   = 8,     // 1..256
    parameter int NUM_TILES = 64     // 1..65535
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] Input_1_V_TDATA,
    input  logic              Input_1_V_TVALID,
    output logic              Input_1_V_TREADY,
    output logic [DATA_W-1:0] Output_1_V_TDATA,
    output logic              Output_1_V_TVALID,
    input  logic              Output_1_V_TREADY
);

    localparam int BEAT_W = (ACC_LEN   > 1) ? $clog2(ACC_LEN)   : 1;
    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ACC_LEN - 1);
    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_acc;
    logic [BEAT_W-1:0]   r_beat;
    logic [TILE_W-1:0]   r_tile;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_vld;

    logic                w_final_beat;
    logic                w_last_tile;
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_result;

    assign w_final_beat = (r_beat == BEAT_LAST);
    assign w_last_tile  = (r_tile == TILE_LAST);
    assign w_out_fire   = r_out_vld & Output_1_V_TREADY;

    // Only the final beat needs the output register; it may reload in the
    // same cycle the downstream drains it, giving back-to-back results.
    assign w_in_ready = (r_state == S_RUN) &
                        (!w_final_beat | !r_out_vld | Output_1_V_TREADY);
    assign w_in_fire  = Input_1_V_TVALID & w_in_ready;

    // Sign-extend both operands by one bit so the sum never loses its sign.
    assign w_sum = {r_acc[DATA_W-1], r_acc} +
                   {Input_1_V_TDATA[DATA_W-1], Input_1_V_TDATA};

`ifdef TILE_ACCUMULATE_SATURATE_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // The top two bits of the widened sum disagree exactly on overflow; the
    // extra top bit carries the true sign and picks the clamp direction.
    always_comb begin
        w_result = w_sum[DATA_W-1:0];
        if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
            w_result = w_sum[DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign w_result = w_sum[DATA_W-1:0];
`endif

    // ------------------------------------------------------------------------
    // FSM next state and control outputs
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        ap_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_in_fire && w_final_beat && w_last_tile) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_out_vld || Output_1_V_TREADY) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                ap_done     = 1'b1;
                ap_ready    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, datapath and output register
    // ------------------------------------------------------------------------
    // NOTE: reset is tested inside the clocked block and is absent from the
    // sensitivity list, which makes it synchronous; all state uses <= so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_beat     <= '0;
            r_tile     <= '0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE && ap_start) begin
                r_acc  <= '0;
                r_beat <= '0;
                r_tile <= '0;
            end else if (w_in_fire) begin
                if (w_final_beat) begin
                    r_acc  <= '0;
                    r_beat <= '0;
                    r_tile <= r_tile + TILE_W'(1);
                end else begin
                    r_acc  <= w_result;
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end

            // A reload wins over a drain in the same cycle.
            if (w_in_fire && w_final_beat) begin
                r_out_data <= w_result;
                r_out_vld  <= 1'b1;
            end else if (w_out_fire) begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    assign Input_1_V_TREADY  = w_in_ready;
    assign Output_1_V_TDATA  = r_out_data;
    assign Output_1_V_TVALID = r_out_vld;

endmodule

// File: tb/tb_tile_accumulate.sv
// ============================================================================
// tb_tile_accumulate
//
// Four instances of tile_accumulate with different parameters:
//   u0 : ACC_LEN=4, NUM_TILES=2  (basic sum, backpressure, reset mid-tile)
//   u1 : ACC_LEN=2, NUM_TILES=2  (overflow behaviour)
//   u2 : ACC_LEN=1, NUM_TILES=3  (pass-through)
//   u3 : ACC_LEN=2, NUM_TILES=1  (continuous start)
// Expected results follow TILE_ACCUMULATE_SATURATE_EN when it is defined.
// ============================================================================
module tb_tile_accumulate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rst_n;
    logic [3:0]       start;
    logic [3:0]       in_valid;
    logic [3:0][31:0] in_data;
    logic [3:0]       out_ready;

    logic [3:0]       done;
    logic [3:0]       idle;
    logic [3:0]       ready;
    logic [3:0]       in_ready;
    logic [3:0]       out_valid;
    logic [3:0][31:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    tile_accumulate #(.DATA_W(32), .ACC_LEN(4), .NUM_TILES(2)) u0 (
        .ap_clk(clk), .ap_rst_n(rst_n[0]), .ap_start(start[0]),
        .ap_done(done[0]), .ap_idle(idle[0]), .ap_ready(ready[0]),
        .Input_1_V_TDATA(in_data[0]), .Input_1_V_TVALID(in_valid[0]),
        .Input_1_V_TREADY(in_ready[0]),
        .Output_1_V_TDATA(out_data[0]), .Output_1_V_TVALID(out_valid[0]),
        .Output_1_V_TREADY(out_ready[0]));

    tile_accumulate #(.DATA_W(32), .ACC_LEN(2), .NUM_TILES(2)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n[1]), .ap_start(start[1]),
        .ap_done(done[1]), .ap_idle(idle[1]), .ap_ready(ready[1]),
        .Input_1_V_TDATA(in_data[1]), .Input_1_V_TVALID(in_valid[1]),
        .Input_1_V_TREADY(in_ready[1]),
        .Output_1_V_TDATA(out_data[1]), .Output_1_V_TVALID(out_valid[1]),
        .Output_1_V_TREADY(out_ready[1]));

    tile_accumulate #(.DATA_W(32), .ACC_LEN(1), .NUM_TILES(3)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n[2]), .ap_start(start[2]),
        .ap_done(done[2]), .ap_idle(idle[2]), .ap_ready(ready[2]),
        .Input_1_V_TDATA(in_data[2]), .Input_1_V_TVALID(in_valid[2]),
        .Input_1_V_TREADY(in_ready[2]),
        .Output_1_V_TDATA(out_data[2]), .Output_1_V_TVALID(out_valid[2]),
        .Output_1_V_TREADY(out_ready[2]));

    tile_accumulate #(.DATA_W(32), .ACC_LEN(2), .NUM_TILES(1)) u3 (
        .ap_clk(clk), .ap_rst_n(rst_n[3]), .ap_start(start[3]),
        .ap_done(done[3]), .ap_idle(idle[3]), .ap_ready(ready[3]),
        .Input_1_V_TDATA(in_data[3]), .Input_1_V_TVALID(in_valid[3]),
        .Input_1_V_TREADY(in_ready[3]),
        .Output_1_V_TDATA(out_data[3]), .Output_1_V_TVALID(out_valid[3]),
        .Output_1_V_TREADY(out_ready[3]));

    // ------------------------------------------------------------------------
    // Collector: records every output handshake, counts done pulses and any
    // cycle where ap_ready disagrees with ap_done.
    // ------------------------------------------------------------------------
    logic [31:0] got [4][16];
    int n_got     [4] = '{0, 0, 0, 0};
    int n_done    [4] = '{0, 0, 0, 0};
    int n_rdy_bad [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (out_valid[u] && out_ready[u] && n_got[u] < 16) begin
                got[u][n_got[u]] <= out_data[u];
                n_got[u]         <= n_got[u] + 1;
            end
            if (done[u])            n_done[u]    <= n_done[u] + 1;
            if (ready[u] != done[u]) n_rdy_bad[u] <= n_rdy_bad[u] + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Drivers (all resume at posedge + 1)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int u);
        start[u] = 1'b1;
        step();
        start[u] = 1'b0;
    endtask

    task automatic send(input int u, input logic [31:0] word);
        logic accepted;
        logic ok;
        ok = 1'b0;
        in_valid[u] = 1'b1;
        in_data[u]  = word;
        for (int k = 0; k < 50; k++) begin
            #1;
            accepted = in_ready[u];
            @(posedge clk);
            #1;
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid[u] = 1'b0;
        n_vec++;
        if (!ok) begin
            $display("FAIL send_timeout u%0d: word %h accepted=0 required=1", u, word);
            n_err++;
        end
    endtask

    task automatic wait_done(input int u, input int target);
        for (int k = 0; k < 100; k++) begin
            if (n_done[u] >= target) break;
            step();
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 4'b0000;
        start     = 4'b0000;
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 4'b1111;
        repeat (3) step();
        n_vec++; if (idle[0] !== 1'b1) begin $display("FAIL reset_idle: got %b expected 1", idle[0]); n_err++; end
        n_vec++; if (done[0] !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done[0]); n_err++; end
        n_vec++; if (ready[0] !== 1'b0) begin $display("FAIL reset_ready: got %b expected 0", ready[0]); n_err++; end
        n_vec++; if (in_ready[0] !== 1'b0) begin $display("FAIL reset_in_tready: got %b expected 0", in_ready[0]); n_err++; end
        n_vec++; if (out_valid !== 4'b0000) begin $display("FAIL reset_out_tvalid: got %b expected 0000", out_valid); n_err++; end
        n_vec++; if (out_data[0] !== 32'h0) begin $display("FAIL reset_out_tdata: got %h expected 00000000", out_data[0]); n_err++; end
        rst_n = 4'b1111;
        step();
    endtask

    task automatic test_basic_sum();
        int b;
        int d;
        b = n_got[0];
        d = n_done[0];
        start_run(0);
        for (int i = 1; i <= 8; i++) send(0, 32'(i));
        wait_done(0, d + 1);
        step();
        n_vec++; if (n_got[0] - b != 2) begin $display("FAIL basic_count: got %0d results expected 2", n_got[0] - b); n_err++; end
        n_vec++; if (got[0][b] !== 32'd10) begin $display("FAIL basic_r0: got %h expected 0000000a", got[0][b]); n_err++; end
        n_vec++; if (got[0][b+1] !== 32'd26) begin $display("FAIL basic_r1: got %h expected 0000001a", got[0][b+1]); n_err++; end
        n_vec++; if (n_done[0] != d + 1) begin $display("FAIL basic_done_pulses: got %0d expected 1", n_done[0] - d); n_err++; end
        n_vec++; if (idle[0] !== 1'b1) begin $display("FAIL basic_idle_return: got %b expected 1", idle[0]); n_err++; end
    endtask

    task automatic test_backpressure();
        int b;
        int d;
        logic [31:0] words [5] = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd8};
        logic        exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        b = n_got[0];
        d = n_done[0];
        out_ready[0] = 1'b0;
        start_run(0);
        for (int i = 1; i <= 4; i++) send(0, 32'(i));
        // First result is now held; keep the downstream stalled for 5 cycles.
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = words[k];
            #1;
            n_vec++; if (out_valid[0] !== 1'b1) begin $display("FAIL bp_tvalid[%0d]: got %b expected 1", k, out_valid[0]); n_err++; end
            n_vec++; if (out_data[0] !== 32'd10) begin $display("FAIL bp_tdata[%0d]: got %h expected 0000000a", k, out_data[0]); n_err++; end
            n_vec++; if (in_ready[0] !== exp_rdy[k]) begin $display("FAIL bp_in_tready[%0d]: got %b expected %b", k, in_ready[0], exp_rdy[k]); n_err++; end
            step();
        end
        out_ready[0] = 1'b1;
        send(0, 32'd8);
        wait_done(0, d + 1);
        n_vec++; if (n_got[0] - b != 2) begin $display("FAIL bp_count: got %0d results expected 2", n_got[0] - b); n_err++; end
        n_vec++; if (got[0][b] !== 32'd10) begin $display("FAIL bp_r0: got %h expected 0000000a", got[0][b]); n_err++; end
        n_vec++; if (got[0][b+1] !== 32'd26) begin $display("FAIL bp_r1: got %h expected 0000001a", got[0][b+1]); n_err++; end
        n_vec++; if (n_done[0] != d + 1) begin $display("FAIL bp_done_pulses: got %0d expected 1", n_done[0] - d); n_err++; end
        step();
    endtask

    task automatic test_reset_mid_tile();
        int b;
        b = n_got[0];
        start_run(0);
        send(0, 32'd9);
        send(0, 32'd9);
        rst_n[0] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        n_vec++; if (idle[0] !== 1'b1) begin $display("FAIL rst_mid_idle: got %b expected 1", idle[0]); n_err++; end
        n_vec++; if (in_ready[0] !== 1'b0) begin $display("FAIL rst_mid_in_tready: got %b expected 0", in_ready[0]); n_err++; end
        n_vec++; if (out_valid[0] !== 1'b0) begin $display("FAIL rst_mid_tvalid: got %b expected 0", out_valid[0]); n_err++; end
        start_run(0);
        for (int i = 0; i < 4; i++) send(0, 32'd1);
        for (int k = 0; k < 10 && n_got[0] == b; k++) step();
        n_vec++; if (n_got[0] - b != 1) begin $display("FAIL rst_mid_count: got %0d results expected 1", n_got[0] - b); n_err++; end
        n_vec++; if (got[0][b] !== 32'd4) begin $display("FAIL rst_mid_sum: got %h expected 00000004", got[0][b]); n_err++; end
    endtask

    task automatic test_overflow();
        int b;
        logic [31:0] exp0;
        logic [31:0] exp1;
`ifdef TILE_ACCUMULATE_SATURATE_EN
        exp0 = 32'h7FFF_FFFF;
        exp1 = 32'h8000_0000;
`else
        exp0 = 32'h8000_0000;
        exp1 = 32'h7FFF_FFFF;
`endif
        b = n_got[1];
        start_run(1);
        send(1, 32'h7FFF_FFFF);
        send(1, 32'h0000_0001);
        send(1, 32'h8000_0000);
        send(1, 32'hFFFF_FFFF);
        wait_done(1, 1);
        n_vec++; if (n_got[1] - b != 2) begin $display("FAIL ovf_count: got %0d results expected 2", n_got[1] - b); n_err++; end
        n_vec++; if (got[1][b] !== exp0) begin $display("FAIL ovf_pos: got %h expected %h", got[1][b], exp0); n_err++; end
        n_vec++; if (got[1][b+1] !== exp1) begin $display("FAIL ovf_neg: got %h expected %h", got[1][b+1], exp1); n_err++; end
    endtask

    task automatic test_pass_through();
        int b;
        b = n_got[2];
        start_run(2);
        send(2, 32'hFFFF_FFFB);
        send(2, 32'h0000_0000);
        send(2, 32'h0000_0007);
        // Third result is valid and accepted at the coming edge; done follows.
        n_vec++; if (done[2] !== 1'b0) begin $display("FAIL pt_done_early: got %b expected 0", done[2]); n_err++; end
        step();
        n_vec++; if (done[2] !== 1'b1) begin $display("FAIL pt_done_pulse: got %b expected 1", done[2]); n_err++; end
        step();
        n_vec++; if ({done[2], idle[2]} !== 2'b01) begin $display("FAIL pt_done_end: got done,idle=%b expected 01", {done[2], idle[2]}); n_err++; end
        n_vec++; if (n_got[2] - b != 3) begin $display("FAIL pt_count: got %0d results expected 3", n_got[2] - b); n_err++; end
        n_vec++; if (got[2][b] !== 32'hFFFF_FFFB) begin $display("FAIL pt_r0: got %h expected fffffffb", got[2][b]); n_err++; end
        n_vec++; if (got[2][b+1] !== 32'h0) begin $display("FAIL pt_r1: got %h expected 00000000", got[2][b+1]); n_err++; end
        n_vec++; if (got[2][b+2] !== 32'h7) begin $display("FAIL pt_r2: got %h expected 00000007", got[2][b+2]); n_err++; end
    endtask

    task automatic test_continuous_start();
        int b;
        int pulses;
        logic [15:0] tr_done;
        logic [15:0] tr_idle;
        b = n_got[3];
        pulses = 0;
        fork
            begin
                start[3] = 1'b1;
                send(3, 32'd1);
                send(3, 32'd1);
                send(3, 32'd2);
                send(3, 32'd2);
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    step();
                    tr_done[c] = done[3];
                    tr_idle[c] = idle[3];
                end
            end
        join
        start[3] = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (tr_done[c]) begin
                pulses++;
                n_vec++; if (tr_idle[c+1] !== 1'b1) begin $display("FAIL cont_idle_after_done[%0d]: got %b expected 1", c, tr_idle[c+1]); n_err++; end
                n_vec++; if (tr_idle[c+2] !== 1'b0) begin $display("FAIL cont_idle_one_cycle[%0d]: got %b expected 0", c, tr_idle[c+2]); n_err++; end
            end
        end
        n_vec++; if (pulses != 2) begin $display("FAIL cont_done_pulses: got %0d expected 2", pulses); n_err++; end
        n_vec++; if (n_got[3] - b != 2) begin $display("FAIL cont_count: got %0d results expected 2", n_got[3] - b); n_err++; end
        n_vec++; if (got[3][b] !== 32'd2) begin $display("FAIL cont_r0: got %h expected 00000002", got[3][b]); n_err++; end
        n_vec++; if (got[3][b+1] !== 32'd4) begin $display("FAIL cont_r1: got %h expected 00000004", got[3][b+1]); n_err++; end
    endtask

    task automatic test_ready_tracks_done();
        for (int u = 0; u < 4; u++) begin
            n_vec++;
            if (n_rdy_bad[u] != 0) begin
                $display("FAIL ready_vs_done u%0d: got %0d disagreeing cycles expected 0", u, n_rdy_bad[u]);
                n_err++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_backpressure();
        test_reset_mid_tile();
        test_overflow();
        test_pass_through();
        test_continuous_start();
        test_ready_tracks_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
